// File: rtl/sys_ctrl_rx_pkg.sv
// Shared definitions for the system-side command decoder: opcodes, FSM states, operand addresses.
// No logic of its own; latency and backpressure are defined by the modules that import it.
// Helper functions classify opcodes and the states in which incoming bytes are dropped.
package sys_ctrl_rx_pkg;

    // Frame opcodes (first byte of every command frame)
    localparam logic [7:0] OP_WRITE   = 8'hAA;
    localparam logic [7:0] OP_READ    = 8'hBB;
    localparam logic [7:0] OP_ALU_OPS = 8'hCC;
    localparam logic [7:0] OP_ALU_NOP = 8'hDD;

    // Register-file locations that receive the ALU operands
    localparam int ALU_A_ADDR = 0;
    localparam int ALU_B_ADDR = 1;

    // ALU function code width
    localparam int ALU_FUN_W = 4;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_ADDR  = 4'd1,
        ST_WR_DATA  = 4'd2,
        ST_RD_ADDR  = 4'd3,
        ST_RD_WAIT  = 4'd4,
        ST_ALU_A    = 4'd5,
        ST_ALU_B    = 4'd6,
        ST_ALU_FUN  = 4'd7,
        ST_ALU_WAIT = 4'd8,
        ST_TX_LO    = 4'd9,
        ST_TX_HI    = 4'd10
    } state_t;

    // True for the four recognised opcodes
    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WRITE) || (b == OP_READ) || (b == OP_ALU_OPS) || (b == OP_ALU_NOP);
    endfunction

    // States waiting on a result or on the transmitter: a received byte here is lost
    function automatic logic drops_bytes(input state_t s);
        return (s == ST_RD_WAIT) || (s == ST_ALU_WAIT) || (s == ST_TX_LO) || (s == ST_TX_HI);
    endfunction

endpackage

// File: rtl/sys_ctrl_tx_seq.sv
// Transmit byte sequencer: holds one or two result bytes and presents them on tx_data/tx_valid.
// Latency: tx_valid rises the cycle after a load; next byte (or tx_valid low) the cycle after accept.
// Backpressure: tx_data/tx_valid frozen while tx_busy=1; a byte moves only when tx_valid & ~tx_busy.
module sys_ctrl_tx_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    ld_one,
    input  logic [DATA_WIDTH-1:0]   ld_one_dat,
    input  logic                    ld_two,
    input  logic [2*DATA_WIDTH-1:0] ld_two_dat,
    input  logic                    tx_busy,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_valid,
    output logic                    tx_acc
);

    logic [DATA_WIDTH-1:0] hi_q;
    logic                  hi_pend;

    // A byte leaves in any cycle where it is offered and the transmitter is free
    assign tx_acc = tx_valid && !tx_busy;

    // Load a new result, or step to the high byte / go idle after each accepted byte
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_data  <= '0;
            tx_valid <= 1'b0;
            hi_q     <= '0;
            hi_pend  <= 1'b0;
        end else if (ld_two) begin
            tx_data  <= ld_two_dat[DATA_WIDTH-1:0];
            hi_q     <= ld_two_dat[2*DATA_WIDTH-1:DATA_WIDTH];
            hi_pend  <= 1'b1;
            tx_valid <= 1'b1;
        end else if (ld_one) begin
            tx_data  <= ld_one_dat;
            hi_pend  <= 1'b0;
            tx_valid <= 1'b1;
        end else if (tx_acc) begin
            if (hi_pend) begin
                tx_data <= hi_q;
                hi_pend <= 1'b0;
            end else begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sys_ctrl_rx.sv
// Command decoder: turns framed rx bytes into register-file strobes, ALU starts and tx results.
// Latency: every strobe is registered, high one cycle after the accepting rx_valid/alu_valid/rf_rd_valid.
// Backpressure: none on rx (bytes arriving while waiting/transmitting are dropped with cmd_err); tx honours tx_busy.
module sys_ctrl_rx
    import sys_ctrl_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic                    rx_valid,
    output logic [ADDR_WIDTH-1:0]   rf_addr,
    output logic                    rf_wr_en,
    output logic [DATA_WIDTH-1:0]   rf_wr_data,
    output logic                    rf_rd_en,
    input  logic [DATA_WIDTH-1:0]   rf_rd_data,
    input  logic                    rf_rd_valid,
    output logic                    alu_en,
    output logic [ALU_FUN_W-1:0]    alu_fun,
    output logic                    alu_clk_en,
    input  logic [2*DATA_WIDTH-1:0] alu_out,
    input  logic                    alu_valid,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_valid,
    input  logic                    tx_busy,
    output logic                    cmd_err
);

    state_t state, state_nxt;

    logic [7:0]            rx_op;
    logic [ADDR_WIDTH-1:0] rx_addr;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_nxt;
    logic [ADDR_WIDTH-1:0] rf_addr_nxt;
    logic [DATA_WIDTH-1:0] rf_wr_data_nxt;
    logic [ALU_FUN_W-1:0]  alu_fun_nxt;
    logic                  rf_wr_en_nxt, rf_rd_en_nxt, alu_en_nxt, alu_clk_en_nxt, cmd_err_nxt;
    logic                  ld_one, ld_two, tx_acc;

    assign rx_op   = rx_data[7:0];
    assign rx_addr = rx_data[ADDR_WIDTH-1:0];

    // State register; reset abandons any partial frame
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame sequencing: advance on each received byte, result pulse or accepted tx byte
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_op)
                        OP_WRITE:   state_nxt = ST_WR_ADDR;
                        OP_READ:    state_nxt = ST_RD_ADDR;
                        OP_ALU_OPS: state_nxt = ST_ALU_A;
                        OP_ALU_NOP: state_nxt = ST_ALU_FUN;
                        default:    state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_WR_ADDR:  if (rx_valid)    state_nxt = ST_WR_DATA;
            ST_WR_DATA:  if (rx_valid)    state_nxt = ST_IDLE;
            ST_RD_ADDR:  if (rx_valid)    state_nxt = ST_RD_WAIT;
            ST_RD_WAIT:  if (rf_rd_valid) state_nxt = ST_TX_HI;
            ST_ALU_A:    if (rx_valid)    state_nxt = ST_ALU_B;
            ST_ALU_B:    if (rx_valid)    state_nxt = ST_ALU_FUN;
            ST_ALU_FUN:  if (rx_valid)    state_nxt = ST_ALU_WAIT;
            ST_ALU_WAIT: if (alu_valid)   state_nxt = ST_TX_LO;
            ST_TX_LO:    if (tx_acc)      state_nxt = ST_TX_HI;
            ST_TX_HI:    if (tx_acc)      state_nxt = ST_IDLE;
            default:                      state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; address/data/function hold when not updated
    always_comb begin
        rf_wr_en_nxt   = 1'b0;
        rf_rd_en_nxt   = 1'b0;
        alu_en_nxt     = 1'b0;
        alu_clk_en_nxt = 1'b0;
        cmd_err_nxt    = 1'b0;
        rf_addr_nxt    = rf_addr;
        rf_wr_data_nxt = rf_wr_data;
        alu_fun_nxt    = alu_fun;
        wr_addr_nxt    = wr_addr_q;
        ld_one         = 1'b0;
        ld_two         = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rx_valid && !is_opcode(rx_op)) cmd_err_nxt = 1'b1;
            end
            ST_WR_ADDR: begin
                if (rx_valid) wr_addr_nxt = rx_addr;
            end
            ST_WR_DATA: begin
                if (rx_valid) begin
                    rf_wr_en_nxt   = 1'b1;
                    rf_addr_nxt    = wr_addr_q;
                    rf_wr_data_nxt = rx_data;
                end
            end
            ST_RD_ADDR: begin
                if (rx_valid) begin
                    rf_rd_en_nxt = 1'b1;
                    rf_addr_nxt  = rx_addr;
                end
            end
            ST_RD_WAIT: begin
                ld_one = rf_rd_valid;
            end
            ST_ALU_A: begin
                if (rx_valid) begin
                    rf_wr_en_nxt   = 1'b1;
                    rf_addr_nxt    = ADDR_WIDTH'(ALU_A_ADDR);
                    rf_wr_data_nxt = rx_data;
                end
            end
            ST_ALU_B: begin
                if (rx_valid) begin
                    rf_wr_en_nxt   = 1'b1;
                    rf_addr_nxt    = ADDR_WIDTH'(ALU_B_ADDR);
                    rf_wr_data_nxt = rx_data;
                end
            end
            ST_ALU_FUN: begin
                if (rx_valid) begin
                    alu_en_nxt     = 1'b1;
                    alu_fun_nxt    = rx_data[ALU_FUN_W-1:0];
                    alu_clk_en_nxt = 1'b1;
                end
            end
            ST_ALU_WAIT: begin
                // Keep the ALU clocked through the cycle that follows its result
                alu_clk_en_nxt = 1'b1;
                ld_two         = alu_valid;
            end
            default: begin
            end
        endcase
        // A byte arriving while a result is pending or being sent is lost
        if (rx_valid && drops_bytes(state)) cmd_err_nxt = 1'b1;
    end

    // Output and frame-context registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rf_addr    <= '0;
            rf_wr_en   <= 1'b0;
            rf_wr_data <= '0;
            rf_rd_en   <= 1'b0;
            alu_en     <= 1'b0;
            alu_fun    <= '0;
            alu_clk_en <= 1'b0;
            cmd_err    <= 1'b0;
            wr_addr_q  <= '0;
        end else begin
            rf_addr    <= rf_addr_nxt;
            rf_wr_en   <= rf_wr_en_nxt;
            rf_wr_data <= rf_wr_data_nxt;
            rf_rd_en   <= rf_rd_en_nxt;
            alu_en     <= alu_en_nxt;
            alu_fun    <= alu_fun_nxt;
            alu_clk_en <= alu_clk_en_nxt;
            cmd_err    <= cmd_err_nxt;
            wr_addr_q  <= wr_addr_nxt;
        end
    end

    sys_ctrl_tx_seq #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tx_seq (
        .CLK        (CLK),
        .RST        (RST),
        .ld_one     (ld_one),
        .ld_one_dat (rf_rd_data),
        .ld_two     (ld_two),
        .ld_two_dat (alu_out),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_acc     (tx_acc)
    );

endmodule

// File: tb/tb_sys_ctrl_rx.sv
// Bench for sys_ctrl_rx: directed frame table, randomized frames against a frame-level model,
// and hand-written sequences for busy hold, ALU clock enable, same-cycle drops and mid-frame reset.
module tb_sys_ctrl_rx;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [3:0]  rf_addr;
    logic        rf_wr_en;
    logic [7:0]  rf_wr_data;
    logic        rf_rd_en;
    logic [7:0]  rf_rd_data = 8'h00;
    logic        rf_rd_valid = 1'b0;
    logic        alu_en;
    logic [3:0]  alu_fun;
    logic        alu_clk_en;
    logic [15:0] alu_out = 16'h0000;
    logic        alu_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_busy = 1'b0;
    logic        cmd_err;

    always #5 CLK = ~CLK;

    sys_ctrl_rx #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .CLK(CLK), .RST(RST),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rf_addr(rf_addr), .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data),
        .rf_rd_en(rf_rd_en), .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
        .alu_en(alu_en), .alu_fun(alu_fun), .alu_clk_en(alu_clk_en),
        .alu_out(alu_out), .alu_valid(alu_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
        .cmd_err(cmd_err)
    );

    // One frame with the events it must produce
    typedef struct {
        int          nb;
        logic [7:0]  b [4];
        logic [7:0]  rd;
        logic [15:0] res;
        int          n_wr;
        logic [11:0] wr [2];
        int          n_rd;
        logic [3:0]  rda;
        int          n_alu;
        logic [3:0]  fun;
        int          n_tx;
        logic [7:0]  tx [2];
        int          n_err;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    // Observed events
    logic [11:0] got_wr[$];
    logic [3:0]  got_rd[$];
    logic [3:0]  got_fun[$];
    logic [7:0]  got_tx[$];
    int          err_cnt;

    // Responder state
    logic [7:0]  rd_q[$];
    logic [15:0] alu_q[$];
    int          rd_tmr = 0, alu_tmr = 0;
    bit          auto_resp = 1'b1;
    bit          rand_busy = 1'b0;
    bit          busy_fix = 1'b0;
    bit          m_rdv = 1'b0, m_aluv = 1'b0;
    logic [7:0]  m_rdd = 8'h00;
    logic [15:0] m_alu = 16'h0000;
    bit          p_vld = 1'b0, p_busy = 1'b0;
    logic [7:0]  p_dat = 8'h00;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Sample outputs mid-cycle and log events
    task automatic mon();
        if (rf_wr_en) got_wr.push_back({rf_addr, rf_wr_data});
        if (rf_rd_en) begin
            got_rd.push_back(rf_addr);
            if (auto_resp) rd_tmr = $urandom_range(1, 3);
        end
        if (alu_en) begin
            got_fun.push_back(alu_fun);
            if (auto_resp) alu_tmr = $urandom_range(1, 4);
        end
        if (cmd_err) err_cnt++;
        if (p_vld && p_busy) begin
            chk("tx_hold_vld", 32'(tx_valid), 32'd1);
            chk("tx_hold_dat", 32'(tx_data), 32'(p_dat));
        end
        if (tx_valid && !tx_busy) got_tx.push_back(tx_data);
        p_vld  = tx_valid;
        p_busy = tx_busy;
        p_dat  = tx_data;
    endtask

    // Drive one clock cycle of inputs; returns 1ns after the closing edge
    task automatic cyc(input bit v, input logic [7:0] b);
        rx_valid    = v;
        rx_data     = v ? b : 8'($urandom);
        rf_rd_valid = 1'b0;
        alu_valid   = 1'b0;
        if (auto_resp) begin
            if (rd_tmr > 0) begin
                rd_tmr--;
                if (rd_tmr == 0 && rd_q.size() > 0) begin
                    rf_rd_valid = 1'b1;
                    rf_rd_data  = rd_q.pop_front();
                end
            end
            if (alu_tmr > 0) begin
                alu_tmr--;
                if (alu_tmr == 0 && alu_q.size() > 0) begin
                    alu_valid = 1'b1;
                    alu_out   = alu_q.pop_front();
                end
            end
        end else begin
            rf_rd_valid = m_rdv;
            rf_rd_data  = m_rdd;
            alu_valid   = m_aluv;
            alu_out     = m_alu;
            m_rdv  = 1'b0;
            m_aluv = 1'b0;
        end
        tx_busy = rand_busy ? ($urandom_range(0, 1) == 1) : busy_fix;
        @(negedge CLK);
        mon();
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t blank();
        vec_t v;
        v.nb = 0; v.b[0] = 0; v.b[1] = 0; v.b[2] = 0; v.b[3] = 0;
        v.rd = 0; v.res = 0; v.n_wr = 0; v.wr[0] = 0; v.wr[1] = 0;
        v.n_rd = 0; v.rda = 0; v.n_alu = 0; v.fun = 0;
        v.n_tx = 0; v.tx[0] = 0; v.tx[1] = 0; v.n_err = 0;
        return v;
    endfunction

    function automatic vec_t row(input int nb, input logic [7:0] b0, b1, b2, b3,
                                 input logic [7:0] rd, input logic [15:0] res,
                                 input int n_wr, input logic [11:0] w0, w1,
                                 input int n_rd, input logic [3:0] rda,
                                 input int n_alu, input logic [3:0] fun,
                                 input int n_tx, input logic [7:0] t0, t1, input int n_err);
        vec_t v;
        v.nb = nb; v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
        v.rd = rd; v.res = res; v.n_wr = n_wr; v.wr[0] = w0; v.wr[1] = w1;
        v.n_rd = n_rd; v.rda = rda; v.n_alu = n_alu; v.fun = fun;
        v.n_tx = n_tx; v.tx[0] = t0; v.tx[1] = t1; v.n_err = n_err;
        return v;
    endfunction

    // Reference model: a random frame and its consequences from the command rules
    function automatic vec_t gen();
        vec_t v = blank();
        int k = $urandom_range(0, 4);
        logic [7:0] x = 8'($urandom);
        logic [7:0] y = 8'($urandom);
        logic [7:0] z = 8'($urandom);
        case (k)
            0: begin
                v.nb = 3; v.b[0] = 8'hAA; v.b[1] = x; v.b[2] = y;
                v.n_wr = 1; v.wr[0] = {x[3:0], y};
            end
            1: begin
                v.nb = 2; v.b[0] = 8'hBB; v.b[1] = x; v.rd = y;
                v.n_rd = 1; v.rda = x[3:0]; v.n_tx = 1; v.tx[0] = y;
            end
            2: begin
                v.nb = 4; v.b[0] = 8'hCC; v.b[1] = x; v.b[2] = y; v.b[3] = z;
                v.res = 16'($urandom);
                v.n_wr = 2; v.wr[0] = {4'd0, x}; v.wr[1] = {4'd1, y};
                v.n_alu = 1; v.fun = z[3:0];
                v.n_tx = 2; v.tx[0] = v.res[7:0]; v.tx[1] = v.res[15:8];
            end
            3: begin
                v.nb = 2; v.b[0] = 8'hDD; v.b[1] = z; v.res = 16'($urandom);
                v.n_alu = 1; v.fun = z[3:0];
                v.n_tx = 2; v.tx[0] = v.res[7:0]; v.tx[1] = v.res[15:8];
            end
            default: begin
                while (x == 8'hAA || x == 8'hBB || x == 8'hCC || x == 8'hDD) x = 8'($urandom);
                v.nb = 1; v.b[0] = x; v.n_err = 1;
            end
        endcase
        return v;
    endfunction

    // Send one frame, let it drain, compare observed events with the expectation
    task automatic run_vec(input vec_t v, input string tag);
        got_wr.delete(); got_rd.delete(); got_fun.delete(); got_tx.delete();
        rd_q.delete(); alu_q.delete();
        err_cnt = 0;
        if (v.n_rd > 0) rd_q.push_back(v.rd);
        if (v.n_alu > 0) alu_q.push_back(v.res);
        for (int i = 0; i < v.nb; i++) begin
            cyc(1'b1, v.b[i]);
            repeat ($urandom_range(0, 2)) cyc(1'b0, 8'h00);
        end
        repeat (30) cyc(1'b0, 8'h00);
        chk({tag, " wr_cnt"}, got_wr.size(), v.n_wr);
        for (int i = 0; i < v.n_wr && i < got_wr.size(); i++) chk({tag, " wr"}, 32'(got_wr[i]), 32'(v.wr[i]));
        chk({tag, " rd_cnt"}, got_rd.size(), v.n_rd);
        if (v.n_rd > 0 && got_rd.size() > 0) chk({tag, " rd_addr"}, 32'(got_rd[0]), 32'(v.rda));
        chk({tag, " alu_cnt"}, got_fun.size(), v.n_alu);
        if (v.n_alu > 0 && got_fun.size() > 0) chk({tag, " alu_fun"}, 32'(got_fun[0]), 32'(v.fun));
        chk({tag, " tx_cnt"}, got_tx.size(), v.n_tx);
        for (int i = 0; i < v.n_tx && i < got_tx.size(); i++) chk({tag, " tx"}, 32'(got_tx[i]), 32'(v.tx[i]));
        chk({tag, " err_cnt"}, err_cnt, v.n_err);
    endtask

    initial begin
        //            nb  b0     b1     b2     b3     rd     res       nwr w0       w1       nrd rda   nalu fun  ntx t0     t1     err
        tbl[0] = row(3, 8'hAA, 8'h05, 8'h3C, 8'h00, 8'h00, 16'h0000, 1, 12'h53C, 12'h000, 0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00, 0);
        tbl[1] = row(3, 8'hAA, 8'hF7, 8'h99, 8'h00, 8'h00, 16'h0000, 1, 12'h799, 12'h000, 0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00, 0);
        tbl[2] = row(2, 8'hBB, 8'h05, 8'h00, 8'h00, 8'h3C, 16'h0000, 0, 12'h000, 12'h000, 1, 4'h5, 0, 4'h0, 1, 8'h3C, 8'h00, 0);
        tbl[3] = row(4, 8'hCC, 8'h12, 8'h34, 8'h01, 8'h00, 16'h0446, 2, 12'h012, 12'h134, 0, 4'h0, 1, 4'h1, 2, 8'h46, 8'h04, 0);
        tbl[4] = row(2, 8'hDD, 8'h02, 8'h00, 8'h00, 8'h00, 16'h1234, 0, 12'h000, 12'h000, 0, 4'h0, 1, 4'h2, 2, 8'h34, 8'h12, 0);
        tbl[5] = row(2, 8'hDD, 8'hF7, 8'h00, 8'h00, 8'h00, 16'hBEEF, 0, 12'h000, 12'h000, 0, 4'h0, 1, 4'h7, 2, 8'hEF, 8'hBE, 0);
        tbl[6] = row(1, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 12'h000, 12'h000, 0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00, 1);
        tbl[7] = row(2, 8'hBB, 8'h1A, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 12'h000, 12'h000, 1, 4'hA, 0, 4'h0, 1, 8'h00, 8'h00, 0);

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst rf_addr", 32'(rf_addr), 0);
        chk("rst rf_wr_en", 32'(rf_wr_en), 0);
        chk("rst rf_wr_data", 32'(rf_wr_data), 0);
        chk("rst rf_rd_en", 32'(rf_rd_en), 0);
        chk("rst alu_en", 32'(alu_en), 0);
        chk("rst alu_fun", 32'(alu_fun), 0);
        chk("rst alu_clk_en", 32'(alu_clk_en), 0);
        chk("rst tx_data", 32'(tx_data), 0);
        chk("rst tx_valid", 32'(tx_valid), 0);
        chk("rst cmd_err", 32'(cmd_err), 0);
        RST = 1'b0;
        cyc(1'b0, 8'h00);

        // Directed frame table with random transmitter stalls
        rand_busy = 1'b1;
        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Randomized frames against the model
        for (int i = 0; i < 40; i++) run_vec(gen(), $sformatf("rnd%0d", i));

        // Read with a byte dropped in RD_WAIT and a 3-cycle transmitter stall
        rand_busy = 1'b0; auto_resp = 1'b0; busy_fix = 1'b1;
        cyc(1'b1, 8'hBB);
        cyc(1'b1, 8'h05);
        chk("seq_rd rd_en", 32'(rf_rd_en), 1);
        chk("seq_rd addr", 32'(rf_addr), 5);
        chk("seq_rd wr_en", 32'(rf_wr_en), 0);
        cyc(1'b1, 8'h77);
        chk("seq_rd drop err", 32'(cmd_err), 1);
        chk("seq_rd drop rd_en", 32'(rf_rd_en), 0);
        cyc(1'b0, 8'h00);
        chk("seq_rd err pulse", 32'(cmd_err), 0);
        m_rdv = 1'b1; m_rdd = 8'h3C;
        cyc(1'b0, 8'h00);
        chk("seq_rd tx_valid", 32'(tx_valid), 1);
        chk("seq_rd tx_data", 32'(tx_data), 32'h3C);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'h00);
            chk("seq_rd busy vld", 32'(tx_valid), 1);
            chk("seq_rd busy dat", 32'(tx_data), 32'h3C);
        end
        busy_fix = 1'b0;
        cyc(1'b0, 8'h00);
        chk("seq_rd released", 32'(tx_valid), 0);

        // ALU without operands: clock enable window, result with a same-cycle dropped byte
        cyc(1'b1, 8'hDD);
        chk("seq_alu clk_en pre", 32'(alu_clk_en), 0);
        cyc(1'b1, 8'h02);
        chk("seq_alu alu_en", 32'(alu_en), 1);
        chk("seq_alu fun", 32'(alu_fun), 2);
        chk("seq_alu clk_en", 32'(alu_clk_en), 1);
        chk("seq_alu no wr", 32'(rf_wr_en), 0);
        cyc(1'b0, 8'h00);
        chk("seq_alu en pulse", 32'(alu_en), 0);
        chk("seq_alu clk_en wait", 32'(alu_clk_en), 1);
        m_aluv = 1'b1; m_alu = 16'h0446;
        cyc(1'b1, 8'h11);
        chk("seq_alu same err", 32'(cmd_err), 1);
        chk("seq_alu tx lo vld", 32'(tx_valid), 1);
        chk("seq_alu tx lo", 32'(tx_data), 32'h46);
        chk("seq_alu clk_en post", 32'(alu_clk_en), 1);
        cyc(1'b0, 8'h00);
        chk("seq_alu tx hi vld", 32'(tx_valid), 1);
        chk("seq_alu tx hi", 32'(tx_data), 32'h04);
        chk("seq_alu clk_en off", 32'(alu_clk_en), 0);
        cyc(1'b0, 8'h00);
        chk("seq_alu tx done", 32'(tx_valid), 0);

        // Reset in the middle of a write frame
        cyc(1'b1, 8'hAA);
        cyc(1'b1, 8'h05);
        RST = 1'b1;
        #2;
        chk("seq_rst rf_addr", 32'(rf_addr), 0);
        chk("seq_rst wr_en", 32'(rf_wr_en), 0);
        chk("seq_rst tx_valid", 32'(tx_valid), 0);
        chk("seq_rst wr_data", 32'(rf_wr_data), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        cyc(1'b1, 8'hAA);
        cyc(1'b1, 8'h07);
        chk("seq_rst no early wr", 32'(rf_wr_en), 0);
        cyc(1'b1, 8'h99);
        chk("seq_rst wr_en", 32'(rf_wr_en), 1);
        chk("seq_rst wr addr", 32'(rf_addr), 7);
        chk("seq_rst wr data", 32'(rf_wr_data), 32'h99);
        cyc(1'b0, 8'h00);
        chk("seq_rst wr pulse", 32'(rf_wr_en), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_ctrl_rx.md
# sys_ctrl_rx

Command-decode controller on the system-clock side of the multi-clock design. It consumes the byte stream delivered by the data synchronizer (one byte plus a single-cycle valid pulse) and decodes framed commands into register-file write/read strobes and ALU operations. Results go to the transmit path as bytes over a valid/busy handshake.

## Interface
- DATA_WIDTH, 8, byte width of rx/tx/register data
- ADDR_WIDTH, 4, register-file address width
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- rx_data  in  DATA_WIDTH  synchronized received byte, valid only when rx_valid=1
- rx_valid  in  1  single-cycle pulse, one per byte
- rf_addr  out  ADDR_WIDTH  register-file address
- rf_wr_en  out  1  one-cycle write strobe
- rf_wr_data  out  DATA_WIDTH  write data
- rf_rd_en  out  1  one-cycle read strobe
- rf_rd_data  in  DATA_WIDTH  read data
- rf_rd_valid  in  1  read data valid pulse
- alu_en  out  1  one-cycle ALU start strobe
- alu_fun  out  4  ALU function code
- alu_clk_en  out  1  ALU clock-gate enable
- alu_out  in  2*DATA_WIDTH  ALU result
- alu_valid  in  1  ALU result valid pulse
- tx_data  out  DATA_WIDTH  byte to transmitter
- tx_valid  out  1  tx_data holds a byte
- tx_busy  in  1  transmitter cannot accept
- cmd_err  out  1  one-cycle pulse on unknown opcode or dropped byte

## Operation
- Opcodes (first byte of frame): 0xAA write (addr, data); 0xBB read (addr); 0xCC ALU with operands (A, B, fun); 0xDD ALU without operands (fun).
- Address bytes use the low ADDR_WIDTH bits; upper bits ignored.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI.
- IDLE: on rx_valid, go to WR_ADDR/RD_ADDR/ALU_A/ALU_FUN by opcode; other value -> cmd_err pulse, remain IDLE.
- WR_ADDR -> WR_DATA on byte (latch addr); WR_DATA on byte -> rf_wr_en with latched addr/data, -> IDLE.
- RD_ADDR on byte -> rf_rd_en, -> RD_WAIT; RD_WAIT on rf_rd_valid capture rf_rd_data into tx_data, -> TX_HI (single-byte send).
- ALU_A on byte -> write to addr 0; ALU_B on byte -> write to addr 1; then ALU_FUN.
- ALU_FUN on byte -> alu_fun = byte[3:0], alu_en pulse, -> ALU_WAIT; on alu_valid capture alu_out, -> TX_LO.
- TX_LO sends alu_out low byte, then TX_HI sends high byte (or read byte), then IDLE.
- rx_valid in RD_WAIT, ALU_WAIT, TX_LO, TX_HI: byte dropped, cmd_err pulse.

## Timing
- Reset: state IDLE; all outputs 0, including rf_addr, rf_wr_data, alu_fun, tx_data.
- All outputs registered. Strobes (rf_wr_en, rf_rd_en, alu_en, cmd_err) are high exactly one cycle, the cycle after the accepting rx_valid/alu_valid.
- alu_clk_en high from the cycle after the ALU_FUN byte until the cycle after alu_valid.
- tx handshake: tx_valid asserted the cycle after data capture; tx_data stable while tx_valid=1; transfer completes in a cycle with tx_valid=1 and tx_busy=0; next byte (or tx_valid=0) the following cycle.
- rx_valid and rf_rd_valid/alu_valid in the same cycle: result captured, byte dropped with cmd_err.
- RST mid-frame: immediate return to IDLE, all strobes and tx_valid cleared; partial frame discarded.

## Structure
- Shared package: opcode constants (0xAA/0xBB/0xCC/0xDD), state encoding, operand addresses 0/1.
- Single module; the tx byte-sequencer (TX_LO/TX_HI with busy handshake) may be split into sub-module sys_ctrl_tx_seq.

## Test plan
- Bytes AA,05,3C -> rf_wr_en one cycle with rf_addr=5, rf_wr_data=0x3C; state IDLE.
- BB,05 then rf_rd_valid with 0x3C -> rf_rd_en one cycle, tx_valid with tx_data=0x3C held across 3 cycles of tx_busy=1, released after accept.
- CC,12,34,01 then alu_valid with 0x0446 -> writes addr0=0x12, addr1=0x34, alu_en with alu_fun=1, tx sends 0x46 then 0x04.
- DD,02 -> no rf writes, alu_en with alu_fun=2, alu_clk_en high until alu_valid.
- Byte 0x55 in IDLE, and byte during RD_WAIT -> cmd_err pulse each, no strobes, state unchanged.
- RST asserted after AA,05 -> all outputs 0; subsequent AA,07,99 writes addr 7 correctly.
